// File: rtl/writer_13.sv
// writer_13: serial bit-stream writer, parallel word in over valid/ready, MSB-first out on w.
// Optional even-parity trailer bit when WRITER_PARITY_EN is defined.
`default_nettype none

module writer_13 #(
   parameter int   WIDTH    = 8,
   parameter int   GAP      = 1,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             w,
   output logic             busy,
   output logic             done
);

   localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH - 1);
   localparam logic [3:0]         c_gap_load = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
   localparam bit                 c_has_gap  = (GAP > 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
`ifdef WRITER_PARITY_EN
      S_PARITY = 2'd3,
`endif
      S_GAP    = 2'd2
   } t_state;

   t_state             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_sh, w_sh_nxt;
   logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]         r_gap, w_gap_nxt;
   logic               r_w, w_w_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_ready, w_ready_nxt;
`ifdef WRITER_PARITY_EN
   logic               r_par, w_par_nxt;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_gap   <= '0;
         r_w     <= IDLE_BIT;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b0;
`ifdef WRITER_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_sh    <= w_sh_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gap   <= w_gap_nxt;
         r_w     <= w_w_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ready <= w_ready_nxt;
`ifdef WRITER_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   // Every output is computed one cycle ahead so the ports come straight from flops.
   always_comb begin
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      w_w_nxt     = IDLE_BIT;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_ready_nxt = 1'b0;
`ifdef WRITER_PARITY_EN
      w_par_nxt   = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            w_ready_nxt = 1'b1;
            if (load_valid && r_ready) begin
               w_state_nxt = S_SHIFT;
               w_sh_nxt    = data_in << 1;
               w_cnt_nxt   = c_cnt_load;
               w_w_nxt     = data_in[WIDTH-1];
               w_busy_nxt  = 1'b1;
               w_ready_nxt = 1'b0;
`ifdef WRITER_PARITY_EN
               w_par_nxt   = ^data_in;
`endif
            end
         end
         S_SHIFT: begin
            if (r_cnt == '0) begin
`ifdef WRITER_PARITY_EN
               w_state_nxt = S_PARITY;
               w_w_nxt     = r_par;
               w_busy_nxt  = 1'b1;
`else
               w_done_nxt = 1'b1;
               if (c_has_gap) begin
                  w_state_nxt = S_GAP;
                  w_gap_nxt   = c_gap_load;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_ready_nxt = 1'b1;
               end
`endif
            end else begin
               w_cnt_nxt  = r_cnt - c_cnt_w'(1);
               w_w_nxt    = r_sh[WIDTH-1];
               w_sh_nxt   = r_sh << 1;
               w_busy_nxt = 1'b1;
            end
         end
`ifdef WRITER_PARITY_EN
         S_PARITY: begin
            w_done_nxt = 1'b1;
            if (c_has_gap) begin
               w_state_nxt = S_GAP;
               w_gap_nxt   = c_gap_load;
            end else begin
               w_state_nxt = S_IDLE;
               w_ready_nxt = 1'b1;
            end
         end
`endif
         S_GAP: begin
            // The done cycle is the first of the GAP idle cycles.
            if (r_gap == 4'd0) begin
               w_state_nxt = S_IDLE;
               w_ready_nxt = 1'b1;
            end else begin
               w_gap_nxt = r_gap - 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign load_ready = r_ready;
   assign w          = r_w;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

`default_nettype wire

// File: doc/writer_13.md
Name: writer_13

Overview:
- Serial bit-stream writer; the transmit-side counterpart of the reader_13 serial detector.
- Accepts a parallel word over a valid/ready handshake and drives it MSB-first on single-bit line w, one bit per clk.
- Idle cycles between frames are programmable.
- Used to generate w stimulus and drive reader-type blocks in-system.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32)
- GAP, 1, number of forced idle cycles after each frame (0..15)
- IDLE_BIT, 0, level driven on w when no frame bit is being sent

Ports:
- clk  input  1  system clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- data_in  input  WIDTH  frame word; sampled only on accept
- load_valid  input  1  upstream offers data_in
- load_ready  output  1  writer can accept a word this cycle
- w  output  1  serial output line, registered
- busy  output  1  high while frame bits are on w
- done  output  1  one-cycle pulse after the last frame bit

Behaviour:
- All outputs are registered. Reset (async assert, sync deassert by design): w=IDLE_BIT, load_ready=0, busy=0, done=0, state=IDLE, shift register and counters cleared.
- load_ready rises on the first clk edge after resetn deasserts.
- States: IDLE, SHIFT, (PARITY under macro), GAP.
- IDLE:
  - load_ready=1, w=IDLE_BIT.
  - Accept = load_valid && load_ready at a clk edge. Capture data_in; go to SHIFT; drop load_ready the same edge.
- SHIFT:
  - Cycle k after accept (k=1..WIDTH) has w = data[WIDTH-k] and busy=1.
  - Bit counter loads WIDTH-1 and decrements.
  - At count 0, go to PARITY if enabled. Otherwise go to GAP if GAP>0, else IDLE.
- First cycle after the last frame bit: done=1 for exactly one cycle, busy=0, w=IDLE_BIT.
- GAP: hold w=IDLE_BIT, load_ready=0 for GAP cycles, then go to IDLE.
- load_ready is low in SHIFT, PARITY and GAP. load_valid is ignored then; the word is not queued.
- Frame spacing:
  - Minimum accept-to-accept distance is WIDTH+GAP+1 cycles (+1 with parity).
  - With GAP=0, the done cycle is also the IDLE cycle and load_ready=1 in it.
- data_in changes after accept have no effect on the frame in flight.
- Reset mid-frame: w returns to IDLE_BIT immediately (async) and the partial frame is discarded. No done pulse.
- Widths: bit counter is ceil(log2(WIDTH+1)) bits; gap counter is 4 bits. No wrap-around is reachable at legal parameter values.

Optional Feature:
- Macro: WRITER_PARITY_EN
- Defined:
  - After the WIDTH data bits, one extra bit is driven in state PARITY: the even-parity bit, XOR of the captured word.
  - busy stays high during it. done moves one cycle later. Frame length is WIDTH+1.
- Not defined: no PARITY state or logic; frame length is exactly WIDTH.

Test Plan:
- Single frame, WIDTH=8, GAP=1, data_in=8'hB5 accepted at cycle 0:
  - w = 1,0,1,1,0,1,0,1 on cycles 1..8; busy=1 on cycles 1..8.
  - done=1 only on cycle 9; load_ready=1 again on cycle 10.
- Busy rejection: hold load_valid=1 with data_in=8'hFF during cycles 1..9 of the frame above.
  - w sequence is unchanged; the second word is accepted only at cycle 10 and its first bit appears on cycle 11.
- Back-to-back, GAP=0, words 8'h0F then 8'hF0 with load_valid held high:
  - w = 0000 1111, then 0 on cycle 9 (IDLE, done=1, second accept), then 1111 0000 on cycles 10..17.
- Reset mid-frame: assert resetn=0 at cycle 4 of an 8'hB5 frame.
  - w=IDLE_BIT immediately, busy=0, no done, load_ready=0 until the first edge after release.
  - Next frame 8'h81 sends 1,0,0,0,0,0,0,1 cleanly.
- WRITER_PARITY_EN defined, data_in=8'hB5 (five ones):
  - Cycle 9 has w=1, busy=1; done on cycle 10.
  - data_in=8'h03 gives parity bit 0.
